// File: rtl/sat_sub_accumulator.sv
// Streaming signed saturating subtract-accumulator: acc <= clamp(base - x), 2-stage valid/ready pipeline.
// Stage A holds the accepted beat; stage B holds the clamped result, which doubles as the accumulator.
module sat_sub_accumulator #(
  parameter int SIZE  = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE-1:0]  in_data,
  input  logic             in_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  out_data,
  output logic             out_sat,
  output logic [CNT_W-1:0] sat_count,
  input  logic             stat_clr
);

  localparam logic [SIZE-1:0]  MAX_POS = {1'b0, {(SIZE-1){1'b1}}};
  localparam logic [SIZE-1:0]  MAX_NEG = {1'b1, {(SIZE-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             a_valid_q, a_valid_d;
  logic [SIZE-1:0]  a_x_q, a_x_d;
  logic             a_clr_q, a_clr_d;
  logic             b_valid_q, b_valid_d;
  logic [SIZE-1:0]  acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             b_load;
  logic             a_accept;
  logic [SIZE-1:0]  base;
  logic [SIZE:0]    diff;
  logic             ovf_pos;
  logic             ovf_neg;
  logic             sat_now;
  logic [SIZE-1:0]  result;

  always_comb begin
    b_load   = a_valid_q && (!b_valid_q || out_ready);
    in_ready = !a_valid_q || !b_valid_q || out_ready;
    a_accept = in_valid && in_ready;

    // One extra bit of headroom: the top two bits disagree exactly when the true difference overflows.
    base    = a_clr_q ? '0 : acc_q;
    diff    = {base[SIZE-1], base} - {a_x_q[SIZE-1], a_x_q};
    ovf_pos = !diff[SIZE] && diff[SIZE-1];
    ovf_neg = diff[SIZE] && !diff[SIZE-1];
    sat_now = ovf_pos || ovf_neg;
    if (ovf_pos) begin
      result = MAX_POS;
    end else if (ovf_neg) begin
      result = MAX_NEG;
    end else begin
      result = diff[SIZE-1:0];
    end
  end

  always_comb begin
    a_valid_d = a_valid_q;
    a_x_d     = a_x_q;
    a_clr_d   = a_clr_q;
    b_valid_d = b_valid_q;
    acc_d     = acc_q;
    sat_d     = sat_q;
    cnt_d     = cnt_q;

    if (a_accept) begin
      a_valid_d = 1'b1;
      a_x_d     = in_data;
      a_clr_d   = in_clear;
    end else if (b_load) begin
      a_valid_d = 1'b0;
    end

    if (b_load) begin
      b_valid_d = 1'b1;
      acc_d     = result;
      sat_d     = sat_now;
    end else if (out_ready) begin
      b_valid_d = 1'b0;
    end

    // A clamp landing in the same cycle as a clear is counted rather than lost.
    if (stat_clr) begin
      cnt_d = (b_load && sat_now) ? CNT_ONE : '0;
    end else if (b_load && sat_now && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q <= 1'b0;
      a_x_q     <= '0;
      a_clr_q   <= 1'b0;
      b_valid_q <= 1'b0;
      acc_q     <= '0;
      sat_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_x_q     <= a_x_d;
      a_clr_q   <= a_clr_d;
      b_valid_q <= b_valid_d;
      acc_q     <= acc_d;
      sat_q     <= sat_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid = b_valid_q;
  assign out_data  = acc_q;
  assign out_sat   = sat_q;
  assign sat_count = cnt_q;

endmodule

// File: tb/tb_sat_sub_accumulator.sv
// Bench for sat_sub_accumulator: directed vector table, backpressure/reset/counter sequences,
// and randomized traffic against an integer-arithmetic reference model with an expected-result queue.
module tb_sat_sub_accumulator;

  localparam int SIZE  = 16;
  localparam int CNT_W = 8;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [SIZE-1:0]  in_data   = '0;
  logic             in_clear  = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [SIZE-1:0]  out_data;
  logic             out_sat;
  logic [CNT_W-1:0] sat_count;
  logic             stat_clr  = 1'b0;

  sat_sub_accumulator #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_clear  (in_clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .sat_count (sat_count),
    .stat_clr  (stat_clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int macc = 0;
  int n_in = 0;
  int n_out = 0;
  int n_acc_sat = 0;
  int ready_mode = 1;
  logic [SIZE:0] exp_q[$];

  typedef struct {
    logic            clr;
    logic [SIZE-1:0] x;
    logic [SIZE-1:0] d;
    logic            s;
  } vec_t;
  vec_t tbl[10];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer subtraction followed by a clamp to the signed 16-bit range.
  function automatic logic [SIZE:0] model_step(logic clr, logic [SIZE-1:0] x);
    int base;
    int d;
    logic sat;
    logic [SIZE-1:0] r;
    base = clr ? 0 : macc;
    d = base - int'($signed(x));
    if (d > 32767) begin
      d = 32767;
      sat = 1'b1;
    end else if (d < -32768) begin
      d = -32768;
      sat = 1'b1;
    end else begin
      sat = 1'b0;
    end
    macc = d;
    r = d[SIZE-1:0];
    return {sat, r};
  endfunction

  // Scoreboard: handshakes seen here complete on the following rising edge.
  initial begin
    logic [SIZE:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid && out_ready) begin
          n_out++;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL spurious_out: got %h expected none", out_data);
          end else begin
            e = exp_q.pop_front();
            check("stream_data", 32'(out_data), 32'(e[SIZE-1:0]));
            check("stream_sat", 32'(out_sat), 32'(e[SIZE]));
          end
        end
        if (in_valid && in_ready) begin
          e = model_step(in_clear, in_data);
          exp_q.push_back(e);
          n_in++;
          if (e[SIZE]) n_acc_sat++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(3, 0) != 0);
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic c, logic [SIZE-1:0] x);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_clear = c;
    in_data  = x;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    step();
    in_valid = 1'b0;
    in_clear = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    step();
  endtask

  initial begin
    int cum;
    logic c;
    logic [SIZE-1:0] x;

    tbl[0] = '{1'b0, 16'd100,  16'hFF9C, 1'b0};
    tbl[1] = '{1'b0, 16'hFFCE, 16'hFFCE, 1'b0};
    tbl[2] = '{1'b1, 16'h8010, 16'h7FF0, 1'b0};
    tbl[3] = '{1'b0, 16'hFFE0, 16'h7FFF, 1'b1};
    tbl[4] = '{1'b0, 16'h0001, 16'h7FFE, 1'b0};
    tbl[5] = '{1'b1, 16'h8000, 16'h7FFF, 1'b1};
    tbl[6] = '{1'b1, 16'h7FFF, 16'h8001, 1'b0};
    tbl[7] = '{1'b0, 16'h0002, 16'h8000, 1'b1};
    tbl[8] = '{1'b1, 16'h0001, 16'hFFFF, 1'b0};
    tbl[9] = '{1'b0, 16'h8000, 16'h7FFF, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    check("rst_sat_count", 32'(sat_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    step();

    cum = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      send(tbl[i].clr, tbl[i].x);
      @(negedge clk);
      check("tbl_early_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      if (tbl[i].s) cum++;
      check("tbl_valid", 32'(out_valid), 32'd1);
      check("tbl_data", 32'(out_data), 32'(tbl[i].d));
      check("tbl_sat", 32'(out_sat), 32'(tbl[i].s));
      check("tbl_sat_count", 32'(sat_count), 32'(cum));
    end

    step();
    ready_mode = 0;
    step();
    send(1'b1, 16'd10);
    send(1'b0, 16'd20);
    in_valid = 1'b1;
    in_data  = 16'd5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", 32'(out_data), 32'h0000FFF6);
    end
    ready_mode = 1;
    step();
    send(1'b0, 16'd5);
    wait_drain();
    check("bp_count", 32'(n_out), 32'(n_in));

    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    @(negedge clk);
    check("stat_clr_only", 32'(sat_count), 32'd0);
    step();
    send(1'b1, 16'h8000);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    @(negedge clk);
    check("stat_clr_with_sat", 32'(sat_count), 32'd1);
    step();
    for (int i = 0; i < 253; i++) send(1'b1, 16'h8000);
    wait_drain();
    check("sat_count_254", 32'(sat_count), 32'd254);
    send(1'b1, 16'h8000);
    wait_drain();
    check("sat_count_255", 32'(sat_count), 32'd255);
    for (int i = 0; i < 46; i++) send(1'b1, 16'h8000);
    wait_drain();
    check("sat_count_hold", 32'(sat_count), 32'd255);

    ready_mode = 0;
    step();
    send(1'b1, 16'd7);
    send(1'b0, 16'd8);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data", 32'(out_data), 32'd0);
    check("arst_out_sat", 32'(out_sat), 32'd0);
    check("arst_sat_count", 32'(sat_count), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    macc = 0;
    ready_mode = 1;
    step();
    rst_n = 1'b1;
    step();
    send(1'b0, 16'd5);
    @(negedge clk);
    @(negedge clk);
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_data", 32'(out_data), 32'h0000FFFB);
    wait_drain();

    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    n_acc_sat = 0;
    n_in = 0;
    n_out = 0;
    ready_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3, 0) == 0) step();
      c = ($urandom_range(7, 0) == 0);
      case ($urandom_range(5, 0))
        0:       x = 16'h7FFF;
        1:       x = 16'h8000;
        2:       x = 16'h0001;
        3:       x = 16'hFFFF;
        default: x = 16'($urandom);
      endcase
      send(c, x);
    end
    wait_drain();
    check("rand_count", 32'(n_out), 32'(n_in));
    check("rand_sat_count", 32'(sat_count), 32'((n_acc_sat > 255) ? 255 : n_acc_sat));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
